// File: rtl/sar_logic_seq_if.sv
// Bundle of sequencer, SPI register, comparator and DAC/readout signals for
// the SAR decision logic. The slave side is the SAR block itself.
interface sar_logic_seq_if #(
    parameter int unsigned NBITS = 16,
    parameter int unsigned CW    = $clog2(NBITS + 1)
) ();
    logic             seq_init;
    logic             seq_update;
    logic [NBITS-1:0] spi_a;
    logic [NBITS-1:0] spi_b;
    logic [CW-1:0]    spi_ncyc;
    logic [1:0]       mode;
    logic             comp;
    logic [NBITS-1:0] dac_state;
    logic [NBITS-1:0] dac_cycle;
    logic             busy;
    logic             done;
    logic [NBITS-1:0] result;

    modport master (
        output seq_init, seq_update, spi_a, spi_b, spi_ncyc, mode, comp,
        input  dac_state, dac_cycle, busy, done, result
    );

    modport slave (
        input  seq_init, seq_update, spi_a, spi_b, spi_ncyc, mode, comp,
        output dac_state, dac_cycle, busy, done, result
    );
endinterface

// File: rtl/sar_logic_seq.sv
// Synchronous SAR bit-decision logic: direct-load, MSB-first decide and
// trial-bit SAR modes with a programmable decision count and latched result.
module sar_logic_seq #(
    parameter int unsigned NBITS = 16,
    parameter int unsigned CW    = $clog2(NBITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    sar_logic_seq_if.slave bus
);
    localparam logic [NBITS-1:0] MSB_ONEHOT = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [CW-1:0]    NBITS_CW   = CW'(NBITS);

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t           r_state, w_state_nxt;
    logic [NBITS-1:0] r_dac, w_dac_nxt;
    logic [NBITS-1:0] r_cyc, w_cyc_nxt;
    logic [NBITS-1:0] r_res, w_res_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [CW-1:0]    w_eff_ncyc;
    logic [NBITS-1:0] w_decided;

    // Out-of-range or zero cycle counts fall back to a full conversion.
    assign w_eff_ncyc = ((bus.spi_ncyc == '0) || (bus.spi_ncyc > NBITS_CW))
                        ? NBITS_CW : bus.spi_ncyc;

    // Write the comparator into the pointed bit; trial mode also sets the next bit down.
    assign w_decided = (r_dac & ~r_cyc)
                     | (bus.comp ? r_cyc : '0)
                     | ((bus.mode == 2'd2) ? (r_cyc >> 1) : '0);

    always_comb begin
        w_state_nxt = r_state;
        w_dac_nxt   = r_dac;
        w_cyc_nxt   = r_cyc;
        w_res_nxt   = r_res;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        if (bus.seq_init) begin
            w_dac_nxt   = (bus.mode == 2'd2) ? (bus.spi_a | MSB_ONEHOT) : bus.spi_a;
            w_cyc_nxt   = MSB_ONEHOT;
            w_cnt_nxt   = w_eff_ncyc;
            w_state_nxt = S_CONV;
            w_busy_nxt  = 1'b1;
        end else if ((r_state == S_CONV) && bus.seq_update) begin
            case (bus.mode)
                2'd0: w_dac_nxt = bus.spi_b;
                2'd1, 2'd2: begin
                    w_dac_nxt = w_decided;
                    w_cyc_nxt = r_cyc >> 1;
                    w_cnt_nxt = r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        w_res_nxt   = w_decided;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_cyc_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_dac   <= '0;
            r_cyc   <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dac   <= w_dac_nxt;
            r_cyc   <= w_cyc_nxt;
            r_res   <= w_res_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.dac_state = r_dac;
    assign bus.dac_cycle = r_cyc;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.result    = r_res;
endmodule

// File: tb/tb_sar_logic_seq.sv
// Directed vector bench for sar_logic_seq at NBITS=8.
module tb_sar_logic_seq;
    localparam int unsigned NB = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sar_logic_seq_if #(.NBITS(NB)) bus ();

    sar_logic_seq #(.NBITS(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit         init;
        bit         upd;
        logic [1:0] mode;
        bit         comp;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] ncyc;
        logic [7:0] e_dac;
        logic [7:0] e_cyc;
        bit         e_busy;
        bit         e_done;
        logic [7:0] e_res;
    } vec_t;

    vec_t vq[$];

    function automatic void add(bit init, bit upd, logic [1:0] mode, bit comp,
                                logic [7:0] a, logic [7:0] b, logic [3:0] ncyc,
                                logic [7:0] e_dac, logic [7:0] e_cyc,
                                bit e_busy, bit e_done, logic [7:0] e_res);
        vec_t v;
        v = '{init, upd, mode, comp, a, b, ncyc, e_dac, e_cyc, e_busy, e_done, e_res};
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [7:0] e_dac, input logic [7:0] e_cyc,
                             input bit e_busy, input bit e_done, input logic [7:0] e_res);
        check("dac_state", idx, 32'(bus.dac_state), 32'(e_dac));
        check("dac_cycle", idx, 32'(bus.dac_cycle), 32'(e_cyc));
        check("busy",      idx, 32'(bus.busy),      32'(e_busy));
        check("done",      idx, 32'(bus.done),      32'(e_done));
        check("result",    idx, 32'(bus.result),    32'(e_res));
    endtask

    task automatic drive(input bit init, input bit upd, input logic [1:0] mode, input bit comp,
                         input logic [7:0] a, input logic [7:0] b, input logic [3:0] ncyc);
        bus.seq_init   = init;
        bus.seq_update = upd;
        bus.mode       = mode;
        bus.comp       = comp;
        bus.spi_a      = a;
        bus.spi_b      = b;
        bus.spi_ncyc   = ncyc;
    endtask

    initial begin
        logic [7:0] acc;
        drive(0, 0, 2'd0, 0, 8'h00, 8'h00, 4'd0);

        // Plain decide, full length: result 0xB2
        add(1,0,1,0,8'h00,8'h00,4'd8, 8'h00,8'h80,1,0,8'h00);
        add(0,1,1,1,8'h00,8'h00,4'd8, 8'h80,8'h40,1,0,8'h00);
        add(0,1,1,0,8'h00,8'h00,4'd8, 8'h80,8'h20,1,0,8'h00);
        add(0,1,1,1,8'h00,8'h00,4'd8, 8'hA0,8'h10,1,0,8'h00);
        add(0,1,1,1,8'h00,8'h00,4'd8, 8'hB0,8'h08,1,0,8'h00);
        add(0,1,1,0,8'h00,8'h00,4'd8, 8'hB0,8'h04,1,0,8'h00);
        add(0,1,1,0,8'h00,8'h00,4'd8, 8'hB0,8'h02,1,0,8'h00);
        add(0,1,1,1,8'h00,8'h00,4'd8, 8'hB2,8'h01,1,0,8'h00);
        add(0,1,1,0,8'h00,8'h00,4'd8, 8'hB2,8'h00,0,1,8'hB2);
        add(0,0,1,0,8'h00,8'h00,4'd8, 8'hB2,8'h00,0,0,8'hB2);
        // Trial-bit SAR: result 0x7F
        add(1,0,2,0,8'h00,8'h00,4'd8, 8'h80,8'h80,1,0,8'hB2);
        add(0,1,2,0,8'h00,8'h00,4'd8, 8'h40,8'h40,1,0,8'hB2);
        add(0,1,2,1,8'h00,8'h00,4'd8, 8'h60,8'h20,1,0,8'hB2);
        add(0,1,2,1,8'h00,8'h00,4'd8, 8'h70,8'h10,1,0,8'hB2);
        add(0,1,2,1,8'h00,8'h00,4'd8, 8'h78,8'h08,1,0,8'hB2);
        add(0,1,2,1,8'h00,8'h00,4'd8, 8'h7C,8'h04,1,0,8'hB2);
        add(0,1,2,1,8'h00,8'h00,4'd8, 8'h7E,8'h02,1,0,8'hB2);
        add(0,1,2,1,8'h00,8'h00,4'd8, 8'h7F,8'h01,1,0,8'hB2);
        add(0,1,2,1,8'h00,8'h00,4'd8, 8'h7F,8'h00,0,1,8'h7F);
        // Direct load, mode switch mid-conversion, idle updates ignored
        add(1,0,0,0,8'h11,8'h5A,4'd1, 8'h11,8'h80,1,0,8'h7F);
        add(0,1,0,0,8'h11,8'h5A,4'd1, 8'h5A,8'h80,1,0,8'h7F);
        add(0,1,1,0,8'h11,8'h5A,4'd1, 8'h5A,8'h00,0,1,8'h5A);
        add(0,1,0,0,8'h11,8'hFF,4'd1, 8'h5A,8'h00,0,0,8'h5A);
        add(0,1,1,1,8'h11,8'hFF,4'd1, 8'h5A,8'h00,0,0,8'h5A);
        // Partial conversion ncyc=3: result 0xEF, extra update ignored
        add(1,0,1,0,8'h0F,8'h00,4'd3, 8'h0F,8'h80,1,0,8'h5A);
        add(0,1,1,1,8'h0F,8'h00,4'd3, 8'h8F,8'h40,1,0,8'h5A);
        add(0,1,1,1,8'h0F,8'h00,4'd3, 8'hCF,8'h20,1,0,8'h5A);
        add(0,1,1,1,8'h0F,8'h00,4'd3, 8'hEF,8'h00,0,1,8'hEF);
        add(0,1,1,1,8'h0F,8'h00,4'd3, 8'hEF,8'h00,0,0,8'hEF);
        // Abort/restart, init beats update, hold mode, mode change mid-conversion
        add(1,0,1,0,8'h00,8'h00,4'd0, 8'h00,8'h80,1,0,8'hEF);
        add(0,1,1,1,8'h00,8'h00,4'd0, 8'h80,8'h40,1,0,8'hEF);
        add(0,1,1,1,8'h00,8'h00,4'd0, 8'hC0,8'h20,1,0,8'hEF);
        add(0,1,1,1,8'h00,8'h00,4'd0, 8'hE0,8'h10,1,0,8'hEF);
        add(0,1,1,1,8'h00,8'h00,4'd0, 8'hF0,8'h08,1,0,8'hEF);
        add(1,0,1,0,8'h33,8'h00,4'd8, 8'h33,8'h80,1,0,8'hEF);
        add(1,1,1,1,8'h44,8'h00,4'd8, 8'h44,8'h80,1,0,8'hEF);
        add(0,1,3,1,8'h44,8'h00,4'd8, 8'h44,8'h80,1,0,8'hEF);
        add(0,1,2,1,8'h44,8'h00,4'd8, 8'hC4,8'h40,1,0,8'hEF);
        add(0,1,1,0,8'h44,8'h00,4'd8, 8'h84,8'h20,1,0,8'hEF);
        // Over-range ncyc=12 runs full length; ncyc changes after init are ignored
        add(1,0,1,0,8'h00,8'h00,4'd12, 8'h00,8'h80,1,0,8'hEF);
        acc = 8'h00;
        for (int k = 0; k < 8; k++) begin
            acc = acc | (8'h80 >> k);
            if (k == 7) add(0,1,1,1,8'h00,8'h00,4'd1, acc,8'h00,0,1,acc);
            else        add(0,1,1,1,8'h00,8'h00,4'd1, acc,8'h80 >> (k+1),1,0,8'hEF);
        end
        // Partial trial-bit SAR leaves the bit below the last decision at 1
        add(1,0,2,0,8'h00,8'h00,4'd2, 8'h80,8'h80,1,0,8'hFF);
        add(0,1,2,1,8'h00,8'h00,4'd2, 8'hC0,8'h40,1,0,8'hFF);
        add(0,1,2,1,8'h00,8'h00,4'd2, 8'hE0,8'h00,0,1,8'hE0);

        #12;
        check_all(-1, 8'h00, 8'h00, 0, 0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].init, vq[i].upd, vq[i].mode, vq[i].comp, vq[i].a, vq[i].b, vq[i].ncyc);
            @(posedge clk);
            #1;
            check_all(i, vq[i].e_dac, vq[i].e_cyc, vq[i].e_busy, vq[i].e_done, vq[i].e_res);
        end

        // Asynchronous reset between edges mid-conversion
        @(negedge clk);
        drive(1, 0, 2'd1, 0, 8'h0F, 8'h00, 4'd8);
        @(negedge clk);
        drive(0, 1, 2'd1, 1, 8'h0F, 8'h00, 4'd8);
        @(posedge clk);
        #1;
        check_all(1000, 8'h8F, 8'h40, 1, 0, 8'hE0);
        @(negedge clk);
        drive(0, 0, 2'd1, 0, 8'h0F, 8'h00, 4'd8);
        #2;
        rst_n = 1'b0;
        #1;
        check_all(1001, 8'h00, 8'h00, 0, 0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 2'd1, 1, 8'h0F, 8'h00, 4'd8);
        @(posedge clk);
        #1;
        check_all(1002, 8'h00, 8'h00, 0, 0, 8'h00);
        @(negedge clk);
        drive(1, 0, 2'd1, 0, 8'h21, 8'h00, 4'd8);
        @(posedge clk);
        #1;
        check_all(1003, 8'h21, 8'h80, 1, 0, 8'h00);
        @(negedge clk);
        drive(0, 0, 2'd1, 0, 8'h21, 8'h00, 4'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
